// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the shared-memory datapath: sequences fetch, decode,
// execute, memory and writeback, owns the NZCV flag register and gates memory strobes.
module multicycle_controller #(
    parameter logic [1:0] PC_INC    = 2'b10,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] Cond,
    input  logic [1:0] Op,
    input  logic [3:0] Funct,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ResultSrc,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemReq,
    output logic       Retire,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXECR  = 4'd2,
        S_EXECI  = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] flags_q;
    logic [3:0] flags_d;

    logic       ir_write_s;
    logic       adr_src_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_control_s;
    logic [1:0] result_src_s;
    logic       pc_write_s;
    logic       reg_write_s;
    logic       mem_write_s;
    logic       mem_req_s;
    logic       retire_s;
    logic       cond_ex_s;

    // nzcv bit order: [3]=N [2]=Z [1]=C [0]=V
    function automatic logic cond_holds(input logic [2:0] cond, input logic [3:0] nzcv);
        logic r;
        case (cond)
            3'b000:  r = nzcv[2];
            3'b001:  r = ~nzcv[2];
            3'b010:  r = (nzcv[3] == nzcv[0]);
            3'b011:  r = (nzcv[3] != nzcv[0]);
            3'b100:  r = nzcv[1];
            3'b101:  r = ~nzcv[1];
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Logical ops only produce meaningful N and Z, so C and V survive them.
    function automatic logic [3:0] next_flags(input logic [1:0] cmd, input logic [3:0] alu_nzcv,
                                              input logic [3:0] cur);
        logic [3:0] r;
        case (cmd)
            2'b00, 2'b01: r = alu_nzcv;
            default:      r = {alu_nzcv[3:2], cur[1:0]};
        endcase
        return r;
    endfunction

    assign cond_ex_s = cond_holds(Cond, flags_q);

    // State and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            flags_q <= FLAGS_RST;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Next-state, flag update and per-state datapath controls.
    always_comb begin
        state_d       = S_FETCH;
        flags_d       = flags_q;
        ir_write_s    = 1'b0;
        adr_src_s     = 1'b0;
        alu_src_a_s   = 1'b0;
        alu_src_b_s   = 2'b00;
        alu_control_s = 2'b00;
        result_src_s  = 2'b00;
        pc_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        mem_write_s   = 1'b0;
        mem_req_s     = 1'b0;
        retire_s      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = PC_INC;
                result_src_s = 2'b10;
                ir_write_s   = MemReady;
                pc_write_s   = MemReady;
                state_d      = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = PC_INC;
                if (!cond_ex_s || (Op == 2'b11)) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    case (Op)
                        2'b00:   state_d = Funct[3] ? S_EXECI : S_EXECR;
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                alu_src_b_s   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_control_s = Funct[2:1];
                state_d       = S_ALUWB;
                if (Funct[0]) begin
                    flags_d = next_flags(Funct[2:1], ALUFlags, flags_q);
                end else begin
                    flags_d = flags_q;
                end
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_b_s = 2'b01;
                state_d     = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                state_d   = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_s   = 1'b1;
                adr_src_s   = 1'b1;
                mem_write_s = MemReady;
                retire_s    = MemReady;
                state_d     = MemReady ? S_FETCH : S_MEMWR;
            end
            S_BRANCH: begin
                alu_src_b_s  = 2'b01;
                result_src_s = 2'b10;
                pc_write_s   = 1'b1;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // A reset cycle must never let a write or memory request escape.
    always_comb begin
        if (!reset) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemReq   = 1'b0;
            Retire   = 1'b0;
        end else begin
            IRWrite  = ir_write_s;
            PCWrite  = pc_write_s;
            RegWrite = reg_write_s;
            MemWrite = mem_write_s;
            MemReq   = mem_req_s;
            Retire   = retire_s;
        end
    end

    assign AdrSrc     = adr_src_s;
    assign ALUSrcA    = alu_src_a_s;
    assign ALUSrcB    = alu_src_b_s;
    assign ALUControl = alu_control_s;
    assign ResultSrc  = result_src_s;
    assign State      = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle control FSM for the processor's shared-memory datapath. One ALU and one unified instruction/data memory port are reused across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK cycles.
- Decodes Op/Funct/Cond and evaluates the condition against an internal NZCV flag register.
- Sequences every datapath enable and mux select, and stalls on a memory ready handshake.
- Replaces the single-cycle decode/conditional pair when the core is built multicycle.

Parameters:
- PC_INC, 2'b10, ALUSrcB select code for the constant PC increment in FETCH.
- FLAGS_RST, 4'b0000, reset value of the internal NZCV register.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- Cond  in  3  instruction condition: 000 EQ, 001 NE, 010 GE, 011 LT, 100 HS, 101 LO, 11x AL.
- Op  in  2  00 data-processing, 01 memory, 10 branch, 11 reserved.
- Funct  in  4  [3]=I (immediate); DP: [2:1] cmd (00 ADD, 01 SUB, 10 AND, 11 ORR), [0] S; MEM: [0] L (1 load, 0 store).
- ALUFlags  in  4  NZCV from ALU, current cycle.
- MemReady  in  1  memory completes the current access this cycle.
- IRWrite  out  1  instruction register load.
- AdrSrc  out  1  memory address: 0 PC, 1 ALUOut.
- ALUSrcA  out  1  0 register A, 1 PC.
- ALUSrcB  out  2  00 register B, 01 extended immediate, 10 PC_INC.
- ALUControl  out  2  ALU operation.
- ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALU result.
- PCWrite  out  1  PC load.
- RegWrite  out  1  register file write.
- MemWrite  out  1  memory write.
- MemReq  out  1  memory access request.
- Retire  out  1  one-cycle pulse when an instruction completes.
- State  out  4  current state encoding, for debug.

Behaviour:
- Reset (reset=0 at an edge): State=FETCH, flags=FLAGS_RST. All write strobes (IRWrite, PCWrite, RegWrite, MemWrite, Retire) and MemReq are 0 during the reset cycle. Reset mid-instruction discards it; nothing is written.
- Outputs are Moore per state. Memory-dependent strobes are additionally gated by MemReady. Unlisted outputs are 0; unlisted selects are 00.
- FETCH(0): MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=PC_INC, ALUControl=00, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0, else goes to DECODE.
- DECODE(1): ALUSrcA=1, ALUSrcB=PC_INC, ALUControl=00 (branch target precompute). CondEx is evaluated from the flag register:
  - EQ: Z. NE: !Z.
  - GE: N==V. LT: N!=V.
  - HS: C. LO: !C.
  - AL: 1.
- DECODE next state:
  - CondEx=0 or Op=11: back to FETCH with Retire=1; no architectural write.
  - Op=00, I=0: EXECR. Op=00, I=1: EXECI.
  - Op=01: MEMADR. Op=10: BRANCH.
- EXECR(2): ALUSrcA=0, ALUSrcB=00, ALUControl=Funct[2:1]; go to ALUWB.
- EXECI(3): as EXECR but ALUSrcB=01; go to ALUWB.
- Flag update, at the end of EXECR/EXECI when S=1:
  - ADD/SUB: flags<=ALUFlags (all four bits).
  - AND/ORR: only N,Z updated; C,V are held.
- ALUWB(4): ResultSrc=00, RegWrite=1, Retire=1; go to FETCH.
- MEMADR(5): ALUSrcA=0, ALUSrcB=01, ALUControl=00. Go to MEMRD if L=1, else MEMWR.
- MEMRD(6): MemReq=1, AdrSrc=1. Waits while MemReady=0; then goes to MEMWB.
- MEMWB(7): ResultSrc=01, RegWrite=1, Retire=1; go to FETCH.
- MEMWR(8): MemReq=1, AdrSrc=1, MemWrite=MemReady, Retire=MemReady. Waits while MemReady=0, then goes to FETCH. MemWrite is asserted for exactly one cycle.
- BRANCH(9): ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=1, Retire=1; go to FETCH.
- Illegal State codes go to FETCH on the next edge.
- Latency with MemReady=1: cond-fail/reserved 2 cycles, branch 3, DP 4, store 4, load 5. Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Flags are visible to the next instruction's DECODE.

Test Plan:
- reset=0 for 2 cycles with MemReady=1 → State=0 and all strobes 0. After reset=1: IRWrite=1, PCWrite=1 in the first FETCH cycle.
- ADD Rx (Op=00, Funct=0001, Cond=110), MemReady=1 → states 0,1,2,4. RegWrite=1 only in cycle 4. With ALUFlags=0100 in EXECR, flags=0100.
- Next instr BEQ (Op=10, Cond=000) with Z=1 → states 0,1,9 and PCWrite=1 in state 9. With Z=0 → states 0,1 only, then FETCH with Retire=1 and PCWrite=0 in DECODE.
- Load (Op=01, Funct=1001) with MemReady low for 3 cycles in MEMRD → MEMRD held 4 cycles, then MEMWB with RegWrite=1. Total 8 cycles.
- Store (Funct=1000) → MemWrite high exactly one cycle, coincident with MemReady=1. reset=0 during a MEMRD stall → FETCH next cycle, no RegWrite.
- ORR with S=1 and ALUFlags=1011 over prior flags 0100 → flags=1011? No: flags=1000. N,Z come from ALUFlags (N=1, Z=0); C,V are held from the prior flags (C=0, V=0).
